rd_dma_sched: RTL and testbench
===============================

RD_DMA_SCHED -- requirements
Module: rd_dma_sched

Interface
REQ-001 SHALL have parameter AMM_CSR_DATA_W, default 32, CSR data width on both the host slave and the rd_dma master.
REQ-002 SHALL have parameter AMM_CSR_ADDR_W, default 4, CSR address width on both the host slave and the rd_dma master.
REQ-003 SHALL have parameter DESC_DEPTH_W, default 3, log2 of descriptor queue depth (8 entries).
REQ-004 SHALL have ports clk_i in 1, the single clock; srst_i in 1, reset, synchronous, active-high.
REQ-005 SHALL have host slave ports: amm_slave_csr_address_i in AMM_CSR_ADDR_W; amm_slave_csr_read_i in 1; amm_slave_csr_readdata_o out AMM_CSR_DATA_W; amm_slave_csr_write_i in 1; amm_slave_csr_writedata_i in AMM_CSR_DATA_W.
REQ-006 SHALL have rd_dma master ports: amm_dma_csr_address_o out AMM_CSR_ADDR_W; amm_dma_csr_write_o out 1; amm_dma_csr_writedata_o out AMM_CSR_DATA_W; amm_dma_csr_read_o out 1; amm_dma_csr_readdata_i in AMM_CSR_DATA_W.
REQ-007 SHALL have job_done_stb_o out 1, a one-cycle pulse per completed job, and queue_irq_o out 1, the level "queue drained" interrupt.

Function
REQ-008 Host CSR map SHALL be: DESC_ADDR (0) write stages base address; DESC_SIZE (1) write stages size and pushes {staged addr, size}; CTRL (2) write, bit0 = enable, bit1 = clear pulse; STATUS (3) read; DONE_CNT (4) read.
REQ-009 STATUS SHALL read as: bit0 = busy (FSM not IDLE); bit1 = overflow sticky; bit2 = irq_en; bits[15:8] = queue level; other bits 0.
REQ-010 Host reads SHALL return data one cycle after amm_slave_csr_read_i; unmapped addresses SHALL read 0.
REQ-011 A push when the queue is full SHALL be dropped and SHALL set overflow; this holds even when a pop occurs in the same cycle.
REQ-012 A push with size 0 SHALL be dropped without setting overflow.
REQ-013 A push and a pop in the same non-full cycle SHALL both succeed, leaving the level unchanged.
REQ-014 The FSM SHALL have states IDLE, WR_BASE, WR_SIZE, WR_RUN, POLL_RD, POLL_WAIT, COMPLETE.
REQ-015 IDLE SHALL go to WR_BASE when enable=1 and the queue is non-empty; otherwise it SHALL stay in IDLE.
REQ-016 WR_BASE, WR_SIZE and WR_RUN SHALL each last one cycle and assert amm_dma_csr_write_o with, respectively: BASE_ADDR/head.addr, SIZE/head.size, RUN/1. Register names come from rd_dma_regs_pkg.
REQ-017 POLL_RD SHALL assert amm_dma_csr_read_o for one cycle at address BASE_ADDR.
REQ-018 POLL_WAIT SHALL sample amm_dma_csr_readdata_i[0], treated as the done flag. If 1 it SHALL go to COMPLETE; if 0 it SHALL return to POLL_RD.
REQ-019 Polling SHALL therefore read at most once every 2 cycles.
REQ-020 COMPLETE SHALL last one cycle, pop the head, pulse job_done_stb_o, increment DONE_CNT (32-bit, wraps) and return to IDLE.
REQ-021 The head descriptor SHALL stay in the queue until COMPLETE.
REQ-022 Master outputs SHALL be 0 in every state that does not drive them.
REQ-023 Write and read SHALL never be asserted together.
REQ-024 Clearing enable during a job SHALL NOT abort it; the job SHALL finish, and no new job SHALL start.
REQ-025 CTRL bit1 = 1 SHALL clear overflow, queue_irq_o and DONE_CNT in the next cycle. If a COMPLETE occurs in the same cycle, the clear SHALL win for DONE_CNT.
REQ-026 CTRL bit2 SHALL set irq_en.
REQ-027 queue_irq_o SHALL be set in the cycle after a COMPLETE that leaves the queue empty, when irq_en=1. It SHALL stay set until cleared, and SHALL be forced to 0 while irq_en=0.

Reset
REQ-028 On srst_i the FSM SHALL go to IDLE, the queue SHALL be emptied, and enable, irq_en, overflow, DONE_CNT, job_done_stb_o, queue_irq_o, all master outputs and amm_slave_csr_readdata_o SHALL be 0.
REQ-029 A reset mid-job SHALL discard all descriptors, including the head, and SHALL NOT write rd_dma.
REQ-030 Staged DESC_ADDR SHALL be non-reset.

Structure
REQ-031 Host register addresses and the FSM state enum SHALL be in the shared package rd_dma_sched_regs_pkg.
REQ-032 The descriptor queue SHALL be the sub-module rd_dma_desc_queue: show-ahead, width 2*AMM_CSR_DATA_W, depth 2**DESC_DEPTH_W, with level, empty and full outputs.

Verification
REQ-033 Enable, then push {0x1000, 0x400}: the master SHALL write BASE_ADDR=0x1000, SIZE=0x400, RUN=1 on 3 consecutive cycles. The model SHALL return done=0 for 3 polls then 1; the bench SHALL then see one job_done_stb_o and DONE_CNT=1.
REQ-034 With enable=0, push 8 descriptors then a 9th: STATUS SHALL show level 8 and overflow=1, and no master activity. After enable, 8 jobs SHALL run in FIFO order.
REQ-035 With irq_en=1, queue 2 jobs: queue_irq_o SHALL rise only after the second COMPLETE. A CTRL write of 0x2 SHALL clear it and DONE_CNT.
REQ-036 Clear enable during POLL of job 1 with 3 queued: job 1 SHALL complete, the level SHALL become 2, and the FSM SHALL stay in IDLE.
REQ-037 Pulse srst_i during POLL_WAIT: all outputs SHALL be 0 and the level SHALL be 0. A following push of size 0 SHALL be ignored, with level still 0 and no overflow.

Source files
------------

// File: rtl/rd_dma_regs_pkg.sv
// Register map of the rd_dma engine CSR slave, as seen from the scheduler's master port.
package rd_dma_regs_pkg;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned SIZE      = 1;
  localparam int unsigned RUN       = 2;
endpackage

// File: rtl/rd_dma_sched_regs_pkg.sv
// Host-facing CSR map and FSM state encoding of the rd_dma descriptor scheduler.
package rd_dma_sched_regs_pkg;
  localparam int unsigned DESC_ADDR = 0;
  localparam int unsigned DESC_SIZE = 1;
  localparam int unsigned CTRL      = 2;
  localparam int unsigned STATUS    = 3;
  localparam int unsigned DONE_CNT  = 4;

  typedef enum logic [2:0] {
    IDLE, WR_BASE, WR_SIZE, WR_RUN, POLL_RD, POLL_WAIT, COMPLETE
  } sched_state_e;
endpackage

// File: rtl/rd_dma_desc_queue.sv
// Show-ahead descriptor FIFO; a push while full is dropped even if a pop lands in the same cycle.
module rd_dma_desc_queue #(
  parameter int DATA_W  = 64,
  parameter int DEPTH_W = 3
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               push_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               pop_i,
  output logic [DATA_W-1:0]  data_o,
  output logic [DEPTH_W:0]   level_o,
  output logic               empty_o,
  output logic               full_o
);
  localparam int LW    = DEPTH_W + 1;
  localparam int DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0]  mem [0:DEPTH-1];
  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]      cnt;
  logic               push_ok, pop_ok;

  assign full_o  = (cnt == LW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign level_o = cnt;
  assign data_o  = mem[rd_ptr];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + DEPTH_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_W'(1);
      if (push_ok && !pop_ok)      cnt <= cnt + LW'(1);
      else if (!push_ok && pop_ok) cnt <= cnt - LW'(1);
    end
  end
endmodule

// File: rtl/rd_dma_sched.sv
// Host-fed descriptor scheduler: programs the rd_dma engine one job at a time and polls it to completion.
module rd_dma_sched
  import rd_dma_sched_regs_pkg::*, rd_dma_regs_pkg::*;
#(
  parameter int AMM_CSR_DATA_W = 32,
  parameter int AMM_CSR_ADDR_W = 4,
  parameter int DESC_DEPTH_W   = 3
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [AMM_CSR_ADDR_W-1:0] amm_slave_csr_address_i,
  input  logic                      amm_slave_csr_read_i,
  output logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_readdata_o,
  input  logic                      amm_slave_csr_write_i,
  input  logic [AMM_CSR_DATA_W-1:0] amm_slave_csr_writedata_i,
  output logic [AMM_CSR_ADDR_W-1:0] amm_dma_csr_address_o,
  output logic                      amm_dma_csr_write_o,
  output logic [AMM_CSR_DATA_W-1:0] amm_dma_csr_writedata_o,
  output logic                      amm_dma_csr_read_o,
  input  logic [AMM_CSR_DATA_W-1:0] amm_dma_csr_readdata_i,
  output logic                      job_done_stb_o,
  output logic                      queue_irq_o
);
  localparam int DW = AMM_CSR_DATA_W;
  localparam int AW = AMM_CSR_ADDR_W;
  localparam int LW = DESC_DEPTH_W + 1;

  sched_state_e    state, state_nxt;
  logic [DW-1:0]   staged_addr, status_w, rd_mux;
  logic [2*DW-1:0] q_head;
  logic [LW-1:0]   q_level;
  logic            q_empty, q_full;
  logic            enable, irq_en, overflow, irq_r;
  logic [31:0]     done_cnt;
  logic            wr_desc_addr, wr_desc_size, wr_ctrl, clr, push, pop, drained;
  logic            unused_rdata;

  assign unused_rdata = ^amm_dma_csr_readdata_i[DW-1:1];

  assign wr_desc_addr = amm_slave_csr_write_i && (amm_slave_csr_address_i == AW'(DESC_ADDR));
  assign wr_desc_size = amm_slave_csr_write_i && (amm_slave_csr_address_i == AW'(DESC_SIZE));
  assign wr_ctrl      = amm_slave_csr_write_i && (amm_slave_csr_address_i == AW'(CTRL));
  assign clr          = wr_ctrl && amm_slave_csr_writedata_i[1];
  assign push         = wr_desc_size && (amm_slave_csr_writedata_i != '0);
  assign pop          = (state == COMPLETE);
  // Last job retired with no refill arriving in the same cycle.
  assign drained      = pop && (q_level == LW'(1)) && !push;

  assign job_done_stb_o = pop;
  assign queue_irq_o    = irq_r && irq_en;

  rd_dma_desc_queue #(.DATA_W(2*DW), .DEPTH_W(DESC_DEPTH_W)) u_queue (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (push),
    .data_i  ({staged_addr, amm_slave_csr_writedata_i}),
    .pop_i   (pop),
    .data_o  (q_head),
    .level_o (q_level),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  always_ff @(posedge clk_i) begin
    if (wr_desc_addr) staged_addr <= amm_slave_csr_writedata_i;
  end

  always_comb begin
    status_w       = '0;
    status_w[0]    = (state != IDLE);
    status_w[1]    = overflow;
    status_w[2]    = irq_en;
    status_w[15:8] = 8'(q_level);
    rd_mux = '0;
    if (amm_slave_csr_address_i == AW'(STATUS))        rd_mux = status_w;
    else if (amm_slave_csr_address_i == AW'(DONE_CNT)) rd_mux = DW'(done_cnt);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable && !q_empty) state_nxt = WR_BASE;
      WR_BASE:   state_nxt = WR_SIZE;
      WR_SIZE:   state_nxt = WR_RUN;
      WR_RUN:    state_nxt = POLL_RD;
      POLL_RD:   state_nxt = POLL_WAIT;
      POLL_WAIT: state_nxt = amm_dma_csr_readdata_i[0] ? COMPLETE : POLL_RD;
      COMPLETE:  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    amm_dma_csr_address_o   = '0;
    amm_dma_csr_write_o     = 1'b0;
    amm_dma_csr_writedata_o = '0;
    amm_dma_csr_read_o      = 1'b0;
    case (state)
      WR_BASE: begin
        amm_dma_csr_write_o     = 1'b1;
        amm_dma_csr_address_o   = AW'(BASE_ADDR);
        amm_dma_csr_writedata_o = q_head[2*DW-1:DW];
      end
      WR_SIZE: begin
        amm_dma_csr_write_o     = 1'b1;
        amm_dma_csr_address_o   = AW'(SIZE);
        amm_dma_csr_writedata_o = q_head[DW-1:0];
      end
      WR_RUN: begin
        amm_dma_csr_write_o     = 1'b1;
        amm_dma_csr_address_o   = AW'(RUN);
        amm_dma_csr_writedata_o = DW'(1);
      end
      POLL_RD: begin
        amm_dma_csr_read_o    = 1'b1;
        amm_dma_csr_address_o = AW'(BASE_ADDR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state                    <= IDLE;
      enable                   <= 1'b0;
      irq_en                   <= 1'b0;
      overflow                 <= 1'b0;
      irq_r                    <= 1'b0;
      done_cnt                 <= '0;
      amm_slave_csr_readdata_o <= '0;
    end else begin
      state <= state_nxt;
      if (wr_ctrl) begin
        enable <= amm_slave_csr_writedata_i[0];
        irq_en <= amm_slave_csr_writedata_i[2];
      end
      if (clr)                 overflow <= 1'b0;
      else if (push && q_full) overflow <= 1'b1;
      // Clear wins over a same-cycle completion.
      if (clr)      done_cnt <= '0;
      else if (pop) done_cnt <= done_cnt + 32'd1;
      if (clr || !irq_en) irq_r <= 1'b0;
      else if (drained)   irq_r <= 1'b1;
      amm_slave_csr_readdata_o <= amm_slave_csr_read_i ? rd_mux : '0;
    end
  end
endmodule

// File: tb/tb_rd_dma_sched.sv
// Scoreboard bench for rd_dma_sched: descriptor-queue model, rd_dma responder and host CSR checks.
module tb_rd_dma_sched;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam logic [3:0] A_BASE = 4'(rd_dma_regs_pkg::BASE_ADDR);
  localparam logic [3:0] A_SIZE = 4'(rd_dma_regs_pkg::SIZE);
  localparam logic [3:0] A_RUN  = 4'(rd_dma_regs_pkg::RUN);
  localparam int H_DADDR  = rd_dma_sched_regs_pkg::DESC_ADDR;
  localparam int H_DSIZE  = rd_dma_sched_regs_pkg::DESC_SIZE;
  localparam int H_CTRL   = rd_dma_sched_regs_pkg::CTRL;
  localparam int H_STATUS = rd_dma_sched_regs_pkg::STATUS;
  localparam int H_DONE   = rd_dma_sched_regs_pkg::DONE_CNT;

  logic clk = 1'b0, srst;
  logic [AW-1:0] s_addr;
  logic s_rd, s_wr;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [AW-1:0] m_addr;
  logic m_wr, m_rd;
  logic [DW-1:0] m_wdata, m_rdata;
  logic job_done, irq;

  rd_dma_sched dut (
    .clk_i(clk), .srst_i(srst),
    .amm_slave_csr_address_i(s_addr), .amm_slave_csr_read_i(s_rd),
    .amm_slave_csr_readdata_o(s_rdata), .amm_slave_csr_write_i(s_wr),
    .amm_slave_csr_writedata_i(s_wdata),
    .amm_dma_csr_address_o(m_addr), .amm_dma_csr_write_o(m_wr),
    .amm_dma_csr_writedata_o(m_wdata), .amm_dma_csr_read_o(m_rd),
    .amm_dma_csr_readdata_i(m_rdata),
    .job_done_stb_o(job_done), .queue_irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] v; string n; } rd_t;

  wr_t         exp_wr[$];
  rd_t         exp_rd[$];
  logic [63:0] mq[$];
  int n_checks = 0, n_errors = 0;
  int n_done = 0, exp_done = 0, n_wr = 0, n_rd = 0, cyc = 0;
  int base_cyc = 0, last_rd_cyc = -10, poll_cnt = 0, polls_needed = 3, reads_in_job = 0;
  logic m_ovf = 1'b0, m_irq_en = 1'b0, rd_q = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rd_q <= s_rd && !srst;
  end

  // Monitor plus rd_dma responder: done flag rises after polls_needed zero polls.
  always @(negedge clk) begin
    wr_t e;
    rd_t x;
    logic [31:0] r;
    if (!srst) begin
      if (m_wr || m_rd) chk("wr_rd_excl", 64'(m_wr && m_rd), 0);
      if (m_wr) begin
        n_wr++;
        if (exp_wr.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(m_addr), 64'(e.a));
          chk("wr_data", 64'(m_wdata), 64'(e.d));
        end
        if (m_addr == A_BASE) base_cyc = cyc;
        if (m_addr == A_RUN) begin
          chk("wr_consecutive", 64'(cyc - base_cyc), 2);
          poll_cnt = 0;
          reads_in_job = 0;
        end
      end
      if (m_rd) begin
        n_rd++;
        chk("poll_gap", 64'((cyc - last_rd_cyc) >= 2), 1);
        chk("poll_addr", 64'(m_addr), 64'(A_BASE));
        last_rd_cyc = cyc;
        r = $urandom;
        r[0] = (poll_cnt >= polls_needed);
        m_rdata = r;
        poll_cnt++;
        reads_in_job++;
      end
      if (job_done) begin
        n_done++;
        chk("polls_per_job", 64'(reads_in_job), 64'(polls_needed + 1));
      end
      if (rd_q) begin
        if (exp_rd.size() == 0) chk("unexpected_rd", 1, 0);
        else begin
          x = exp_rd.pop_front();
          chk(x.n, 64'(s_rdata), 64'(x.v));
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic hwr(input int a, input logic [31:0] d);
    s_wr = 1'b1; s_addr = AW'(a); s_wdata = d;
    step();
    s_wr = 1'b0;
  endtask

  task automatic hrd(input int a, input logic [31:0] v, input string n);
    s_rd = 1'b1; s_addr = AW'(a);
    exp_rd.push_back('{v, n});
    step();
    s_rd = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(mq.size()), 5'h0, m_irq_en, m_ovf, 1'b0};
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] s);
    hwr(H_DADDR, a);
    if (s != 0) begin
      if (mq.size() == 8) m_ovf = 1'b1;
      else begin
        mq.push_back({a, s});
        exp_wr.push_back('{A_BASE, a});
        exp_wr.push_back('{A_SIZE, s});
        exp_wr.push_back('{A_RUN, 32'd1});
      end
    end
    hwr(H_DSIZE, s);
  endtask

  task automatic ctrl(input logic [31:0] d);
    m_irq_en = d[2];
    if (d[1]) m_ovf = 1'b0;
    hwr(H_CTRL, d);
  endtask

  task automatic run_all();
    exp_done += mq.size();
    mq.delete();
  endtask

  task automatic wait_for(input int target);
    int t = 0;
    while (n_done < target && t < 3000) begin step(); t++; end
    chk("jobs_done", 64'(n_done), 64'(target));
  endtask

  task automatic wait_rd(input int base);
    int t = 0;
    while (n_rd <= base && t < 300) begin step(); t++; end
    chk("poll_seen", 64'(n_rd > base), 1);
  endtask

  task automatic chk_outs_zero(input string n);
    chk({n, "_master"}, {26'h0, m_wr, m_rd, m_addr, m_wdata}, 0);
    chk({n, "_misc"}, {30'h0, job_done, irq, s_rdata}, 0);
  endtask

  initial begin
    int wr0, rd0, base, ie, jr, nn;
    srst = 1'b1; s_addr = '0; s_rd = 1'b0; s_wr = 1'b0; s_wdata = '0; m_rdata = '0;
    step(3);
    chk_outs_zero("reset");
    srst = 1'b0;
    step();
    hrd(H_STATUS, 0, "status_reset");
    hrd(H_DONE, 0, "donecnt_reset");
    hrd(7, 0, "unmapped_rd");

    // Single job: base/size/run writes, three zero polls then done.
    ctrl(1);
    push(32'h1000, 32'h400);
    run_all();
    wait_for(exp_done);
    step(3);
    hrd(H_DONE, 1, "donecnt_one_job");
    chk("wr_drained_1", 64'(exp_wr.size()), 0);
    hrd(5, 0, "unmapped_rd2");
    ctrl(2);
    hrd(H_DONE, 0, "donecnt_cleared");

    // Fill to 8 with engine disabled, ninth push overflows.
    wr0 = n_wr;
    for (int i = 0; i < 9; i++) push(32'h100 * i + 32'h40, i + 1);
    step(5);
    chk("no_master_while_disabled", 64'(n_wr - wr0), 0);
    hrd(H_STATUS, exp_status(), "status_full_ovf");
    ctrl(1);
    run_all();
    wait_for(exp_done);
    step(3);
    chk("wr_drained_8", 64'(exp_wr.size()), 0);
    hrd(H_DONE, 8, "donecnt_eight");
    ctrl(2);
    hrd(H_STATUS, exp_status(), "status_after_clear");

    // Drain interrupt only after the last of two jobs.
    ctrl(4);
    push(32'hA000, 32'h11);
    push(32'hB000, 32'h22);
    base = n_done;
    ctrl(5);
    run_all();
    wait_for(base + 1);
    chk("irq_after_job1", 64'(irq), 0);
    step(2);
    chk("irq_between_jobs", 64'(irq), 0);
    wait_for(base + 2);
    chk("irq_at_complete", 64'(irq), 0);
    step();
    chk("irq_set", 64'(irq), 1);
    step(3);
    chk("irq_hold", 64'(irq), 1);
    hrd(H_DONE, 2, "donecnt_two");
    hrd(H_STATUS, exp_status(), "status_irq_en");
    ctrl(6);
    chk("irq_cleared", 64'(irq), 0);
    hrd(H_DONE, 0, "donecnt_irq_clear");
    ctrl(0);

    // Disable while polling job 1 of 3: job finishes, nothing new starts.
    for (int i = 0; i < 3; i++) push(32'h3000 + 32'h100 * i, 32'h20 + i);
    rd0 = n_rd;
    ctrl(1);
    wait_rd(rd0);
    ctrl(0);
    wait_for(exp_done + 1);
    exp_done += 1;
    void'(mq.pop_front());
    step(10);
    chk("no_new_job_when_disabled", 64'(exp_wr.size()), 6);
    hrd(H_STATUS, exp_status(), "status_level2_idle");
    ctrl(1);
    run_all();
    wait_for(exp_done);
    step(3);
    chk("wr_drained_3", 64'(exp_wr.size()), 0);
    hrd(H_DONE, 3, "donecnt_three");
    ctrl(2);

    // Randomized rounds.
    for (int r = 0; r < 6; r++) begin
      ie = $urandom_range(0, 1);
      ctrl(32'(ie << 2));
      polls_needed = $urandom_range(0, 3);
      nn = $urandom_range(1, 10);
      for (int i = 0; i < nn; i++)
        push($urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 65535)));
      hrd(H_STATUS, exp_status(), "status_rand_pre");
      jr = mq.size();
      ctrl(32'((ie << 2) | 1));
      run_all();
      wait_for(exp_done);
      step(3);
      chk("wr_drained_rand", 64'(exp_wr.size()), 0);
      hrd(H_DONE, 32'(jr), "donecnt_rand");
      hrd(H_STATUS, exp_status(), "status_rand_post");
      chk("irq_rand", 64'(irq), 64'(ie != 0 && jr > 0));
      ctrl(32'((ie << 2) | 2));
      chk("irq_rand_clear", 64'(irq), 0);
      hrd(H_DONE, 0, "donecnt_rand_clear");
    end
    polls_needed = 3;

    // Reset in POLL_WAIT drops the in-flight job without further rd_dma traffic.
    polls_needed = 1000;
    ctrl(1);
    push(32'h2000, 32'h10);
    rd0 = n_rd;
    wait_rd(rd0);
    step();
    srst = 1'b1;
    step();
    chk_outs_zero("mid_job_reset");
    srst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_irq_en = 1'b0;
    chk("rst_no_pending_wr", 64'(exp_wr.size()), 0);
    polls_needed = 3;
    step();
    chk_outs_zero("after_reset");
    push(32'h5000, 32'h0);
    step(2);
    hrd(H_STATUS, 0, "status_after_reset");
    hrd(H_DONE, 0, "donecnt_after_reset");
    step(5);
    chk("no_job_after_reset", 64'(n_done), 64'(exp_done));
    chk("no_wr_after_reset", 64'(exp_wr.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
